qpulse_dispatcher: RTL and testbench

QPULSE_DISPATCHER -- requirements
Module: qpulse_dispatcher

---
 rtl/qpulse_dispatcher.sv | 147 ++++++++++++++
 tb/tb_qpulse_dispatcher.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/qpulse_dispatcher.sv
// Pulse-descriptor dispatcher: decodes custom-0 instructions, queues pulse
// descriptors for the channel sequencers and keeps the shared timestamp.
//
// state   | meaning
// S_IDLE  | accepting instructions
// S_DELAY | counting down qdelay, instructions stalled
// S_WAIT  | stalled until the FIFO is empty and no channel is busy
module qpulse_dispatcher #(
    parameter int NUM_CH     = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int TIME_W     = 32,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    input  logic [31:0]       instr,
    input  logic [31:0]       rv1,
    output logic              instr_ready,
    output logic              pulse_valid,
    input  logic              pulse_ready,
    output logic [31:0]       pulse_addr,
    output logic [11:0]       pulse_delay,
    output logic [CH_W-1:0]   pulse_ch,
    input  logic [NUM_CH-1:0] ch_busy,
    output logic              qwait_busy,
    output logic [11:0]       qdelay,
    output logic [CNT_W-1:0]  fifo_count,
    output logic              rd_valid,
    output logic [31:0]       rd_data,
    output logic              err_illegal
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [6:0] OPC_CUSTOM = 7'b0001011;

    typedef enum logic [1:0] {S_IDLE, S_DELAY, S_WAIT} state_t;

    state_t            state;
    logic [TIME_W-1:0] timestamp;
    logic [31:0]       mem_addr  [FIFO_DEPTH];
    logic [11:0]       mem_delay [FIFO_DEPTH];
    logic [CH_W-1:0]   mem_ch    [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [2:0]        funct3;
    logic              is_custom;
    logic              is_pulse;
    logic              ch_ok;
    logic              fifo_full;
    logic              accept;
    logic              push;
    logic              pop;
    logic              unused_ok;

    assign funct3      = instr[14:12];
    assign is_custom   = (instr[6:0] == OPC_CUSTOM);
    assign is_pulse    = is_custom && (funct3 == 3'b000);
    assign ch_ok       = ({27'd0, instr[11:7]} < 32'(NUM_CH));
    assign fifo_full   = (fifo_count == CNT_W'(FIFO_DEPTH));
    // A full FIFO stalls only QPULSE; a same-cycle pop does not unblock it.
    assign instr_ready = !reset && (state == S_IDLE) && !(is_pulse && fifo_full);
    assign accept      = instr_valid && instr_ready;
    assign push        = accept && is_pulse && ch_ok;
    assign pulse_valid = (fifo_count != '0);
    assign pop         = pulse_valid && pulse_ready;
    assign pulse_addr  = pulse_valid ? mem_addr[rd_ptr]  : '0;
    assign pulse_delay = pulse_valid ? mem_delay[rd_ptr] : '0;
    assign pulse_ch    = pulse_valid ? mem_ch[rd_ptr]    : '0;
    assign unused_ok   = ^{instr[19:15], rv1};

    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr]  <= rv1;
            mem_delay[wr_ptr] <= instr[31:20];
            mem_ch[wr_ptr]    <= instr[7 +: CH_W];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            qdelay      <= '0;
            timestamp   <= '0;
            rd_valid    <= 1'b0;
            rd_data     <= '0;
            err_illegal <= 1'b0;
            qwait_busy  <= 1'b0;
        end else begin
            rd_valid    <= 1'b0;
            err_illegal <= 1'b0;
            timestamp   <= timestamp + 1'b1;
            case (state)
                S_IDLE: begin
                    if (accept && is_custom) begin
                        case (funct3)
                            3'b000: if (!ch_ok) err_illegal <= 1'b1;
                            3'b001: begin
                                if (instr[31:20] != 12'd0) begin
                                    qdelay <= instr[31:20];
                                    state  <= S_DELAY;
                                end
                            end
                            3'b010: begin
                                state      <= S_WAIT;
                                qwait_busy <= 1'b1;
                            end
                            3'b011: begin
                                rd_valid <= 1'b1;
                                rd_data  <= 32'(timestamp);
                            end
                            3'b100: timestamp <= rv1[TIME_W-1:0];
                            default: err_illegal <= 1'b1;
                        endcase
                    end
                end
                S_DELAY: begin
                    if (qdelay == 12'd1) begin
                        qdelay <= '0;
                        state  <= S_IDLE;
                    end else begin
                        qdelay <= qdelay - 1'b1;
                    end
                end
                S_WAIT: begin
                    if (fifo_count == '0 && ch_busy == '0) begin
                        state      <= S_IDLE;
                        qwait_busy <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_qpulse_dispatcher.sv
// Scoreboard bench for qpulse_dispatcher: directed scenarios plus random
// instruction streams, checked against a queue-based behavioural model.
module tb_qpulse_dispatcher;
    localparam int NCH   = 4;
    localparam int DEPTH = 8;
    localparam logic [6:0] OPC = 7'b0001011;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        instr_valid = 1'b0;
    logic [31:0] instr = '0;
    logic [31:0] rv1 = '0;
    logic        instr_ready;
    logic        pulse_valid;
    logic        pulse_ready = 1'b0;
    logic [31:0] pulse_addr;
    logic [11:0] pulse_delay;
    logic [1:0]  pulse_ch;
    logic [3:0]  ch_busy = '0;
    logic        qwait_busy;
    logic [11:0] qdelay;
    logic [3:0]  fifo_count;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        err_illegal;

    qpulse_dispatcher #(.NUM_CH(NCH), .FIFO_DEPTH(DEPTH), .TIME_W(32)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
        .rv1(rv1), .instr_ready(instr_ready), .pulse_valid(pulse_valid),
        .pulse_ready(pulse_ready), .pulse_addr(pulse_addr),
        .pulse_delay(pulse_delay), .pulse_ch(pulse_ch), .ch_busy(ch_busy),
        .qwait_busy(qwait_busy), .qdelay(qdelay), .fifo_count(fifo_count),
        .rd_valid(rd_valid), .rd_data(rd_data), .err_illegal(err_illegal)
    );

    always #5 clk = ~clk;

    typedef struct { bit en; bit zero; bit rdy; int cnt; bit wt; int qd; } st_t;
    typedef struct { logic [31:0] d; int c; } ev_t;

    st_t         st_q[$];
    ev_t         rd_q[$];
    ev_t         err_q[$];
    logic [45:0] pulse_q[$];

    int  cyc = 0;
    int  checks = 0;
    int  failures = 0;
    bit  done = 1'b0;
    bit  post_rst = 1'b0;
    bit  last_acc = 1'b0;
    bit  g_rand = 1'b0;
    bit  g_pr = 1'b0;
    logic [3:0] g_busy = '0;

    // Behavioural model: FIFO occupancy, remaining stall cycles, wait flag, time.
    int          m_count = 0;
    int          m_delay = 0;
    bit          m_wait = 1'b0;
    logic [31:0] m_ts = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
        end
    endtask

    // Monitor: sole owner of the check counters.
    always @(negedge clk) begin
        st_t s;
        ev_t e;
        logic [45:0] p;
        if (st_q.size() > 0) begin
            s = st_q.pop_front();
            if (s.en) begin
                chk("instr_ready", 64'(instr_ready), 64'(s.rdy));
                chk("fifo_count", 64'(fifo_count), 64'(s.cnt));
                chk("pulse_valid", 64'(pulse_valid), 64'(s.cnt != 0));
                chk("qwait_busy", 64'(qwait_busy), 64'(s.wt));
                chk("qdelay", 64'(qdelay), 64'(s.qd));
                if (s.zero) begin
                    chk("rst_pulse_addr", 64'(pulse_addr), 64'(0));
                    chk("rst_pulse_delay", 64'(pulse_delay), 64'(0));
                    chk("rst_pulse_ch", 64'(pulse_ch), 64'(0));
                    chk("rst_rd_data", 64'(rd_data), 64'(0));
                end
            end
        end
        if (rd_valid) begin
            if (rd_q.size() == 0 || rd_q[0].c != cyc) chk("rd_valid_unexpected", 64'(rd_valid), 64'(0));
            else begin
                e = rd_q.pop_front();
                chk("rd_data", 64'(rd_data), 64'(e.d));
            end
        end else if (rd_q.size() > 0 && rd_q[0].c == cyc) begin
            e = rd_q.pop_front();
            chk("rd_valid_missing", 64'(rd_valid), 64'(1));
        end
        if (err_illegal) begin
            if (err_q.size() == 0 || err_q[0].c != cyc) chk("err_unexpected", 64'(err_illegal), 64'(0));
            else begin
                e = err_q.pop_front();
                chk("err_illegal", 64'(err_illegal), 64'(1));
            end
        end else if (err_q.size() > 0 && err_q[0].c == cyc) begin
            e = err_q.pop_front();
            chk("err_missing", 64'(err_illegal), 64'(1));
        end
        if (pulse_valid && pulse_ready) begin
            if (pulse_q.size() == 0) chk("pulse_unexpected", 64'(pulse_valid), 64'(0));
            else begin
                p = pulse_q.pop_front();
                chk("pulse_desc", 64'({pulse_addr, pulse_delay, pulse_ch}), 64'(p));
            end
        end
        if (cyc > 60000) begin
            $display("FAIL watchdog cycle=%0d actual=running expected=finished", cyc);
            $fatal(1, "watchdog");
        end
        if (done) begin
            chk("pulse_q_left", 64'(pulse_q.size()), 64'(0));
            chk("rd_q_left", 64'(rd_q.size()), 64'(0));
            chk("err_q_left", 64'(err_q.size()), 64'(0));
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    end

    function automatic logic [31:0] mk(input logic [2:0] f3, input logic [4:0] rd, input logic [11:0] imm);
        return {imm, 5'd0, f3, rd, OPC};
    endfunction

    function automatic bit nxt_pr();
        return g_rand ? bit'($urandom_range(0, 1)) : g_pr;
    endfunction

    function automatic logic [3:0] nxt_busy();
        if (!g_rand) return g_busy;
        return ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
    endfunction

    // One clock cycle: drive inputs, record expected status, advance the model.
    task automatic step(input bit v, input logic [31:0] ins, input logic [31:0] r1,
                        input bit pr, input logic [3:0] cb);
        bit idle, cust, ispulse, rdyx, pop, push, nw;
        logic [2:0]  f3;
        int          nd;
        logic [31:0] nts;
        @(posedge clk); #1;
        reset = 1'b0; instr_valid = v; instr = ins; rv1 = r1; pulse_ready = pr; ch_busy = cb;
        #2;
        idle    = (m_delay == 0) && !m_wait;
        cust    = (ins[6:0] == OPC);
        f3      = ins[14:12];
        ispulse = cust && (f3 == 3'd0);
        rdyx    = idle && !(ispulse && m_count == DEPTH);
        st_q.push_back('{en:1'b1, zero:post_rst, rdy:rdyx, cnt:m_count, wt:m_wait, qd:m_delay});
        post_rst = 1'b0;
        pop  = (m_count != 0) && pr;
        push = 1'b0;
        nd   = (m_delay > 0) ? m_delay - 1 : 0;
        nw   = m_wait && !(m_count == 0 && cb == 4'd0);
        nts  = m_ts + 32'd1;
        last_acc = v && rdyx;
        if (last_acc && cust) begin
            case (f3)
                3'd0: begin
                    if (ins[11:7] < NCH) begin
                        push = 1'b1;
                        pulse_q.push_back({r1, ins[31:20], ins[8:7]});
                    end else err_q.push_back('{d:32'd0, c:cyc + 1});
                end
                3'd1: if (ins[31:20] != 12'd0) nd = int'(ins[31:20]);
                3'd2: nw = 1'b1;
                3'd3: rd_q.push_back('{d:m_ts, c:cyc + 1});
                3'd4: nts = r1;
                default: err_q.push_back('{d:32'd0, c:cyc + 1});
            endcase
        end
        m_count = m_count + int'(push) - int'(pop);
        m_delay = nd;
        m_wait  = nw;
        m_ts    = nts;
    endtask

    task automatic rst(input int n);
        @(posedge clk); #1;
        reset = 1'b1; instr_valid = 1'b0; pulse_ready = 1'b0; ch_busy = '0;
        #2;
        st_q.push_back('{en:1'b0, zero:1'b0, rdy:1'b0, cnt:0, wt:1'b0, qd:0});
        for (int i = 1; i < n; i++) begin
            @(posedge clk); #3;
            m_count = 0; m_delay = 0; m_wait = 1'b0; m_ts = '0;
            pulse_q.delete(); rd_q.delete(); err_q.delete();
            st_q.push_back('{en:1'b1, zero:1'b1, rdy:1'b0, cnt:0, wt:1'b0, qd:0});
        end
        post_rst = 1'b1;
    endtask

    task automatic send(input logic [31:0] ins, input logic [31:0] r1);
        int n = 0;
        last_acc = 1'b0;
        while (!last_acc && n < 6000) begin
            step(1'b1, ins, r1, nxt_pr(), nxt_busy());
            n++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'd0, 32'd0, nxt_pr(), nxt_busy());
    endtask

    initial begin
        logic [31:0] ins, r1;
        rst(3);
        // First descriptor reaches the head one cycle after acceptance.
        send(mk(3'd0, 5'd2, 12'd5), 32'h1000);
        idle(1);
        // Fill to capacity, then a stalled QPULSE across a pop.
        for (int i = 0; i < 7; i++) send(mk(3'd0, 5'(i % NCH), 12'(i + 10)), 32'h2000 + 32'(i));
        step(1'b1, mk(3'd0, 5'd1, 12'd99), 32'hCAFE, 1'b0, 4'd0);
        step(1'b1, mk(3'd0, 5'd1, 12'd99), 32'hCAFE, 1'b1, 4'd0);
        step(1'b1, mk(3'd0, 5'd1, 12'd99), 32'hCAFE, 1'b0, 4'd0);
        idle(1);
        g_pr = 1'b1; idle(9); g_pr = 1'b0;
        // QDELAY 3 followed by a QPULSE held on the bus.
        send(mk(3'd1, 5'd0, 12'd3), 32'd0);
        send(mk(3'd0, 5'd1, 12'd7), 32'h0000_00AA);
        send(mk(3'd1, 5'd0, 12'd0), 32'd0);
        g_pr = 1'b1; idle(2); g_pr = 1'b0;
        // QWAIT_BUSY with two entries queued and channel 0 busy.
        send(mk(3'd0, 5'd0, 12'd1), 32'h11);
        send(mk(3'd0, 5'd3, 12'd2), 32'h22);
        send(mk(3'd2, 5'd0, 12'd0), 32'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 32'd0, 1'b0, 4'b0001);
        for (int i = 0; i < 2; i++) step(1'b0, 32'd0, 32'd0, 1'b1, 4'b0001);
        for (int i = 0; i < 2; i++) step(1'b0, 32'd0, 32'd0, 1'b0, 4'b0001);
        step(1'b0, 32'd0, 32'd0, 1'b0, 4'b0000);
        send(mk(3'd3, 5'd0, 12'd0), 32'd0);
        // Timestamp load and wrap.
        send(mk(3'd4, 5'd0, 12'd0), 32'hFFFF_FFFE);
        send(mk(3'd3, 5'd0, 12'd0), 32'd0);
        idle(1);
        send(mk(3'd3, 5'd0, 12'd0), 32'd0);
        // Illegal funct3, out-of-range channel, foreign opcode.
        send(mk(3'd7, 5'd0, 12'd0), 32'd0);
        send(mk(3'd0, 5'd5, 12'd4), 32'h55);
        send({25'h1ABCDE, 7'h33}, 32'h77);
        idle(2);
        // Randomized stream with a reset in the middle.
        g_rand = 1'b1;
        for (int i = 0; i < 300; i++) begin
            r1 = $urandom;
            case ($urandom_range(0, 9))
                0, 1, 2, 9: ins = mk(3'd0, 5'($urandom_range(0, 5)), 12'($urandom));
                3: ins = mk(3'd1, 5'd0, 12'($urandom_range(0, 5)));
                4: ins = mk(3'd2, 5'd0, 12'd0);
                5: ins = mk(3'd3, 5'd0, 12'd0);
                6: begin
                    ins = mk(3'd4, 5'd0, 12'd0);
                    if ($urandom_range(0, 1) == 1) r1 = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                end
                7: ins = mk(3'($urandom_range(5, 7)), 5'd0, 12'd0);
                default: ins = {$urandom_range(0, 32'h1FF_FFFF) , 7'h33} ;
            endcase
            if (i == 150) rst(2);
            send(ins, r1);
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        end
        g_rand = 1'b0; g_pr = 1'b1; g_busy = '0;
        idle(14);
        done = 1'b1;
    end
endmodule
